// File: rtl/mult_div_unit_if.sv
// mult_div_unit_if: issue/result bundle between the pipeline controller
// and the multiply/divide unit (operands and strobe in, Busy and HI/LO out).
interface mult_div_unit_if;
    logic        Start;
    logic [2:0]  MDOp;
    logic [31:0] RegA;
    logic [31:0] RegB;
    logic        Busy;
    logic [31:0] HI;
    logic [31:0] LO;

    modport master (
        output Start, MDOp, RegA, RegB,
        input  Busy, HI, LO
    );

    modport slave (
        input  Start, MDOp, RegA, RegB,
        output Busy, HI, LO
    );
endinterface

// File: rtl/mult_div_unit.sv
// mult_div_unit: multi-cycle multiply/divide unit owning the HI/LO registers.
// The result is computed at issue into a pending register and committed to
// HI/LO after MUL_CYCLES / DIV_CYCLES edges; Busy covers the whole wait.
// Optional feature: define MDU_MADD_EN to make MDOp 111 a signed
// multiply-accumulate into {HI,LO}; when undefined, 111 is a no-op.
module mult_div_unit #(
    parameter int MUL_CYCLES = 5,
    parameter int DIV_CYCLES = 10
) (
    input  logic           clk,
    input  logic           reset,
    mult_div_unit_if.slave bus
);
    localparam int MAX_CYC = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 1);

    localparam logic [2:0] OP_MULT  = 3'b001;
    localparam logic [2:0] OP_MULTU = 3'b010;
    localparam logic [2:0] OP_DIV   = 3'b011;
    localparam logic [2:0] OP_DIVU  = 3'b100;
    localparam logic [2:0] OP_MTHI  = 3'b101;
    localparam logic [2:0] OP_MTLO  = 3'b110;
`ifdef MDU_MADD_EN
    localparam logic [2:0] OP_MADD  = 3'b111;
`endif

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state;
    state_t           next_state;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] next_count;

    logic        busy;
    logic        accept;
    logic        is_div;
    logic        finish;
    logic        move_hi;
    logic        move_lo;
    logic [63:0] result;
    logic [63:0] pend;
    logic [31:0] hi;
    logic [31:0] lo;
`ifdef MDU_MADD_EN
    logic        pend_acc;
`endif

    // Signed 32x32 product, full 64-bit result.
    function automatic logic [63:0] mul_signed(input logic signed [31:0] a,
                                               input logic signed [31:0] b);
        logic signed [63:0] ae;
        logic signed [63:0] be;
        logic signed [63:0] p;
        ae = a;
        be = b;
        p  = ae * be;
        return p;
    endfunction

    // Unsigned 32x32 product, full 64-bit result.
    function automatic logic [63:0] mul_unsigned(input logic [31:0] a,
                                                 input logic [31:0] b);
        return {32'd0, a} * {32'd0, b};
    endfunction

    // Signed divide returning {remainder, quotient}; truncates toward zero,
    // with fixed answers for divide-by-zero and the single overflow case.
    function automatic logic [63:0] div_signed(input logic signed [31:0] a,
                                               input logic signed [31:0] b);
        logic signed [31:0] q;
        logic signed [31:0] r;
        if (b == 32'sd0) begin
            return {a, 32'hFFFF_FFFF};
        end else if (a == 32'sh8000_0000 && b == -32'sd1) begin
            return {32'h0000_0000, 32'h8000_0000};
        end else begin
            q = a / b;
            r = a % b;
            return {r, q};
        end
    endfunction

    // Unsigned divide returning {remainder, quotient}.
    function automatic logic [63:0] div_unsigned(input logic [31:0] a,
                                                 input logic [31:0] b);
        if (b == 32'd0) begin
            return {a, 32'hFFFF_FFFF};
        end else begin
            return {a % b, a / b};
        end
    endfunction

    // State register: IDLE/RUN and the remaining-cycle counter.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
            count <= '0;
        end else begin
            state <= next_state;
            count <= next_count;
        end
    end

    // Next-state logic: load the latency on accept, count down, leave at zero.
    always_comb begin
        next_state = state;
        next_count = count;
        case (state)
            IDLE: begin
                if (accept) begin
                    next_state = RUN;
                    next_count = is_div ? DIV_LOAD : MUL_LOAD;
                end
            end
            RUN: begin
                if (finish) begin
                    next_state = IDLE;
                end else begin
                    next_count = count - 1'b1;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Output/decode logic: Busy, issue acceptance and HI/LO move strobes.
    always_comb begin
        busy    = (state == RUN);
        finish  = (state == RUN) && (count == '0);
        accept  = 1'b0;
        is_div  = 1'b0;
        move_hi = 1'b0;
        move_lo = 1'b0;
        if (state == IDLE && bus.Start) begin
            case (bus.MDOp)
                OP_MULT, OP_MULTU: accept = 1'b1;
                OP_DIV, OP_DIVU: begin
                    accept = 1'b1;
                    is_div = 1'b1;
                end
                OP_MTHI: move_hi = 1'b1;
                OP_MTLO: move_lo = 1'b1;
`ifdef MDU_MADD_EN
                OP_MADD: accept = 1'b1;
`endif
                default: ;
            endcase
        end
    end

    // Arithmetic on the issue-cycle operands, as {HI, LO}.
    always_comb begin
        result = '0;
        case (bus.MDOp)
            OP_MULT:  result = mul_signed(bus.RegA, bus.RegB);
            OP_MULTU: result = mul_unsigned(bus.RegA, bus.RegB);
            OP_DIV:   result = div_signed(bus.RegA, bus.RegB);
            OP_DIVU:  result = div_unsigned(bus.RegA, bus.RegB);
`ifdef MDU_MADD_EN
            OP_MADD:  result = mul_signed(bus.RegA, bus.RegB);
`endif
            default:  result = '0;
        endcase
    end

    // Pending result capture at issue; a reset simply abandons it via the FSM.
    always_ff @(posedge clk) begin
        if (accept) begin
            pend <= result;
`ifdef MDU_MADD_EN
            pend_acc <= (bus.MDOp == OP_MADD);
`endif
        end
    end

    // Architectural HI/LO: commit on completion, or direct moves while idle.
    always_ff @(posedge clk) begin
        if (!reset) begin
            hi <= '0;
            lo <= '0;
        end else if (finish) begin
`ifdef MDU_MADD_EN
            if (pend_acc) begin
                {hi, lo} <= {hi, lo} + pend;
            end else begin
                {hi, lo} <= pend;
            end
`else
            {hi, lo} <= pend;
`endif
        end else begin
            if (move_hi) begin
                hi <= bus.RegA;
            end
            if (move_lo) begin
                lo <= bus.RegA;
            end
        end
    end

    assign bus.Busy = busy;
    assign bus.HI   = hi;
    assign bus.LO   = lo;
endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
- Multi-cycle multiply/divide unit in the execute stage, alongside the ALU; consumes the same RegA/RegB operand pair.
- Holds the architectural HI/LO registers for mult/multu/div/divu/mthi/mtlo.
- Raises Busy while an operation is in flight so the pipeline controller can stall later HI/LO reads and writes.

Parameters:
- MUL_CYCLES, 5, cycles from the accepted Start edge to HI/LO update for multiply ops (>=1).
- DIV_CYCLES, 10, cycles from the accepted Start edge to HI/LO update for divide ops (>=1).

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- reset  input  1  synchronous, active-low; reset==0 at a rising edge clears all state.
- Start  input  1  single-cycle issue strobe qualifying MDOp.
- MDOp  input  3  000 none, 001 mult, 010 multu, 011 div, 100 divu, 101 mthi, 110 mtlo, 111 reserved/optional.
- RegA  input  32  rs operand (multiplicand/dividend/mthi-mtlo source).
- RegB  input  32  rt operand (multiplier/divisor).
- Busy  output  1  high while a multiply/divide is in flight.
- HI  output  32  HI register, registered.
- LO  output  32  LO register, registered.

Behaviour:
- Reset (reset==0 at edge): HI=0, LO=0, Busy=0, counter=0, pending result discarded. Takes priority over everything, including an operation in progress.
- States:
  - IDLE: Busy=0.
  - RUN: Busy=1, counter decrements each cycle.
- Accept: Start=1 in IDLE with MDOp in {001..100} latches RegA/RegB and the op, computes the result into an internal pending register, loads counter=N-1 (N = MUL_CYCLES or DIV_CYCLES), and moves to RUN. Busy goes high the cycle after the Start edge.
- RUN, counter!=0: decrement.
- RUN, counter==0: write the pending result to HI/LO, go to IDLE; Busy falls on the same edge.
- Net timing: HI/LO change exactly N edges after the Start edge; Busy is high for N cycles.
- mthi/mtlo: Start=1 in IDLE writes RegA into HI (101) or LO (110) at that edge; no Busy.
- Start while Busy=1: ignored entirely (any MDOp); the controller must stall. HI/LO hold their values during RUN.
- Start with MDOp=000, or 111 when the optional feature is disabled: no effect.
- Arithmetic:
  - mult: signed 32x32->64.
  - multu: unsigned 32x32->64.
  - Result split {HI,LO} = product[63:32], product[31:0].
  - div/divu: LO = quotient, HI = remainder.
  - Signed div truncates toward zero; remainder takes the dividend's sign.
- Divide by zero (RegB=0, either signedness): LO=0xFFFFFFFF, HI=dividend. Same latency, no exception.
- Signed overflow (0x80000000 div 0xFFFFFFFF): LO=0x80000000, HI=0.
- Operands are sampled only at the Start edge; later RegA/RegB changes have no effect.
- Back-to-back ops: a new Start is accepted at the edge where Busy was 0 before the edge, i.e. the cycle after Busy falls.

Optional Feature:
- Macro: MDU_MADD_EN.
- Defined: MDOp 111 = madd (signed). {HI,LO} <= {HI,LO} + sext64(RegA*RegB) with MUL_CYCLES latency. The accumulate base is HI/LO at the completion edge, and wraps modulo 2^64.
- Undefined: MDOp 111 is a no-op and no accumulate adder is synthesized.

Test Plan:
- Reset, then mult with RegA=0xFFFFFFFE (-2), RegB=0x00000003 -> Busy high 5 cycles; after the 5th edge HI=0xFFFFFFFF, LO=0xFFFFFFFA.
- multu with RegA=0xFFFFFFFF, RegB=0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001 after 5 edges.
- div with RegA=0xFFFFFFF9 (-7), RegB=2 -> after 10 edges LO=0xFFFFFFFD, HI=0xFFFFFFFF. Then divu with RegB=0 and RegA=0x1234 -> LO=0xFFFFFFFF, HI=0x1234.
- div with RegA=0x80000000, RegB=0xFFFFFFFF -> LO=0x80000000, HI=0. During the run, Start+mtlo (RegA=0x55) is ignored: LO shows no 0x55 at any point.
- mthi RegA=0xDEADBEEF then mtlo RegA=0x1 on consecutive cycles -> HI=0xDEADBEEF, LO=1; Busy stays 0.
- Start div, drive reset=0 at the 4th RUN cycle -> next edge Busy=0, HI=LO=0; no late update after release. With MDU_MADD_EN: HI=0, LO=0xFFFFFFFF, madd RegA=1, RegB=1 -> HI=1, LO=0.
